button_debouncer: RTL

//  Input-side counterpart to the LED drivers: conditions an iCESugar push-button pin into clean, CLK-synchronous events.

---
 rtl/button_debouncer_pkg.sv | 20 ++
 rtl/ms_tick_gen.sv | 39 +++
 rtl/button_debouncer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared state encodings, default clock and counter sizing for the button path
package button_debouncer_pkg;

    // Board clock; the blinky tops use the same constant.
    localparam int unsigned DEFAULT_CLK_HZ = 12_000_000;

    typedef enum logic [1:0] {
        ST_RELEASED      = 2'd0,
        ST_PRESS_CHECK   = 2'd1,
        ST_PRESSED       = 2'd2,
        ST_RELEASE_CHECK = 2'd3
    } state_e;

    // Width needed to count 0..n-1; never below one bit so degenerate
    // parameters (n = 1 or 2) still give a legal vector.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running prescaler producing a one-cycle tick at TICK_HZ
//
// Ports:
//   CLK   in  system clock
//   RST   in  synchronous reset, active high
//   TICK  out high for one cycle when the prescaler reaches its last count
module ms_tick_gen
    import button_debouncer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEFAULT_CLK_HZ,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned W   = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronises and debounces a push-button into level, pulses and a press count
//
// Ports:
//   CLK            in   system clock
//   RST            in   synchronous reset, active high
//   BUTTON         in   raw asynchronous, bouncy pin
//   BTN_LEVEL      out  debounced state, 1 = pressed
//   PRESS_PULSE    out  one-cycle pulse per accepted press
//   RELEASE_PULSE  out  one-cycle pulse per accepted release
//   LONG_PULSE     out  one-cycle pulse once LONG_MS ticks into a press
//   PRESS_COUNT    out  accepted-press count, wraps modulo 256
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BUTTON,
    output logic       BTN_LEVEL,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       LONG_PULSE,
    output logic [7:0] PRESS_COUNT
);

    localparam int unsigned DB_W   = cnt_w(DEBOUNCE_MS);
    localparam int unsigned HOLD_W = cnt_w(LONG_MS + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MS - 1);
    // Pin level seen while the button is up.
    localparam logic REL_LVL = ACTIVE_LOW;

    logic tick;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(1000)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .TICK(tick)
    );

    logic              sync1_q, sync2_q;
    state_e            state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q;
    logic              long_fire;
    logic              pressed_s;
    logic              level_q, press_q, release_q, long_q;
    logic [7:0]        count_q;

    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    // Hold timer: counts ticks up to LONG_MS and stays there.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_fire  = 1'b0;
        if (tick && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            long_fire  = (hold_cnt_q == HOLD_PRE) && !long_done_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= REL_LVL;
            sync2_q     <= REL_LVL;
            state_q     <= ST_RELEASED;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            sync1_q   <= BUTTON;
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (pressed_s) begin
                        state_q  <= ST_PRESS_CHECK;
                        db_cnt_q <= '0;
                    end
                end
                ST_PRESS_CHECK: begin
                    if (!pressed_s) begin
                        state_q <= ST_RELEASED;
                    end else if (tick) begin
                        if (db_cnt_q == DB_LAST) begin
                            state_q     <= ST_PRESSED;
                            level_q     <= 1'b1;
                            press_q     <= 1'b1;
                            count_q     <= count_q + 8'd1;
                            hold_cnt_q  <= '0;
                            long_done_q <= 1'b0;
                        end else begin
                            db_cnt_q <= db_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PRESSED: begin
                    hold_cnt_q <= hold_cnt_d;
                    if (long_fire) begin
                        long_q      <= 1'b1;
                        long_done_q <= 1'b1;
                    end
                    if (!pressed_s) begin
                        state_q  <= ST_RELEASE_CHECK;
                        db_cnt_q <= '0;
                    end
                end
                ST_RELEASE_CHECK: begin
                    hold_cnt_q <= hold_cnt_d;
                    if (pressed_s) begin
                        state_q <= ST_PRESSED;
                        if (long_fire) begin
                            long_q      <= 1'b1;
                            long_done_q <= 1'b1;
                        end
                    end else if (tick && (db_cnt_q == DB_LAST)) begin
                        // Release wins over a long-press landing on the same
                        // tick so the two pulses never share a cycle.
                        state_q   <= ST_RELEASED;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        if (tick) begin
                            db_cnt_q <= db_cnt_q + 1'b1;
                        end
                        if (long_fire) begin
                            long_q      <= 1'b1;
                            long_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_RELEASED;
            endcase
        end
    end

    assign BTN_LEVEL     = level_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
    assign LONG_PULSE    = long_q;
    assign PRESS_COUNT   = count_q;

endmodule
